// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one row low at a time, rejects multi-key
// (ghosted) scans, debounces whole-scan results and presents a held key code.
module keypad_scanner #(
    parameter int SETTLE_CYCLES  = 2700,
    parameter int DEBOUNCE_SCANS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [4:0] key,
    output logic       keypad_pressed,
    output logic       press_strobe
);
    localparam int DW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);
    localparam logic [4:0]    NO_KEY     = 5'd31;

    typedef enum logic [1:0] {
        ROW0 = 2'd0,
        ROW1 = 2'd1,
        ROW2 = 2'd2,
        ROW3 = 2'd3
    } scan_state_t;

    function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [4:0] code;
        case ({r, c})
            4'd0:    code = 5'd1;
            4'd1:    code = 5'd2;
            4'd2:    code = 5'd3;
            4'd3:    code = 5'd10;
            4'd4:    code = 5'd4;
            4'd5:    code = 5'd5;
            4'd6:    code = 5'd6;
            4'd7:    code = 5'd11;
            4'd8:    code = 5'd7;
            4'd9:    code = 5'd8;
            4'd10:   code = 5'd9;
            4'd11:   code = 5'd12;
            4'd12:   code = 5'd14;
            4'd13:   code = 5'd0;
            4'd14:   code = 5'd15;
            4'd15:   code = 5'd13;
            default: code = NO_KEY;
        endcase
        return code;
    endfunction

    function automatic logic [2:0] low_count(input logic [3:0] low);
        return {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};
    endfunction

    function automatic logic [1:0] first_low_col(input logic [3:0] low);
        logic [1:0] c;
        if (low[0]) begin
            c = 2'd0;
        end else if (low[1]) begin
            c = 2'd1;
        end else if (low[2]) begin
            c = 2'd2;
        end else begin
            c = 2'd3;
        end
        return c;
    endfunction

    function automatic logic [3:0] row_drive(input scan_state_t s);
        logic [3:0] r;
        case (s)
            ROW0:    r = 4'b1110;
            ROW1:    r = 4'b1101;
            ROW2:    r = 4'b1011;
            ROW3:    r = 4'b0111;
            default: r = 4'b1110;
        endcase
        return r;
    endfunction

    logic [3:0]    cols_meta_r;
    logic [3:0]    cols_sync_r;
    scan_state_t   state_r;
    scan_state_t   state_s;
    logic [DW-1:0] dwell_r;
    logic [DW-1:0] dwell_s;
    logic [3:0]    rows_r;
    logic          sample_s;
    logic [3:0]    low_s;
    logic [1:0]    hit_r;
    logic [1:0]    hit_s;
    logic [1:0]    base_hit_s;
    logic [2:0]    hit_sum_s;
    logic [4:0]    code_r;
    logic [4:0]    code_s;
    logic [4:0]    base_code_s;
    logic          scan_end_s;
    logic [4:0]    scan_result_s;
    logic [4:0]    cand_r;
    logic [4:0]    cand_s;
    logic [SW-1:0] stable_r;
    logic [SW-1:0] stable_s;
    logic          commit_s;
    logic [4:0]    key_r;
    logic [4:0]    key_s;
    logic          pressed_r;
    logic          pressed_s;
    logic          strobe_r;
    logic          strobe_s;

    // Two-stage synchroniser for the asynchronous column inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cols_meta_r <= 4'b1111;
            cols_sync_r <= 4'b1111;
        end else begin
            cols_meta_r <= cols;
            cols_sync_r <= cols_meta_r;
        end
    end

    // Row dwell timing and next-row selection.
    always_comb begin
        sample_s = (dwell_r == DWELL_LAST);
        state_s  = state_r;
        dwell_s  = dwell_r;
        if (sample_s) begin
            dwell_s = '0;
            case (state_r)
                ROW0:    state_s = ROW1;
                ROW1:    state_s = ROW2;
                ROW2:    state_s = ROW3;
                ROW3:    state_s = ROW0;
                default: state_s = ROW0;
            endcase
        end else begin
            dwell_s = dwell_r + DW'(1);
        end
    end

    // Accumulate hits across the rows of one scan; ROW0 starts from empty.
    always_comb begin
        low_s       = ~cols_sync_r;
        base_hit_s  = hit_r;
        base_code_s = code_r;
        if (state_r == ROW0) begin
            base_hit_s  = 2'd0;
            base_code_s = NO_KEY;
        end else begin
            base_hit_s  = hit_r;
            base_code_s = code_r;
        end
        hit_sum_s = {1'b0, base_hit_s} + low_count(low_s);
        if (hit_sum_s >= 3'd2) begin
            hit_s = 2'd2;
        end else begin
            hit_s = hit_sum_s[1:0];
        end
        if ((base_hit_s == 2'd0) && (low_s != 4'b0000)) begin
            code_s = key_code(state_r, first_low_col(low_s));
        end else begin
            code_s = base_code_s;
        end
        scan_end_s    = sample_s && (state_r == ROW3);
        scan_result_s = (hit_s == 2'd1) ? code_s : NO_KEY;
    end

    // Debounce the per-scan result and decide commits; a key-to-key change
    // always passes through "none" first.
    always_comb begin
        cand_s    = cand_r;
        stable_s  = stable_r;
        key_s     = key_r;
        pressed_s = pressed_r;
        strobe_s  = 1'b0;
        if (scan_end_s) begin
            if (scan_result_s == cand_r) begin
                cand_s   = cand_r;
                stable_s = (stable_r == STABLE_MAX) ? STABLE_MAX : stable_r + SW'(1);
            end else begin
                cand_s   = scan_result_s;
                stable_s = SW'(1);
            end
        end else begin
            cand_s   = cand_r;
            stable_s = stable_r;
        end
        commit_s = scan_end_s && (stable_s == STABLE_MAX) && (cand_s != key_r);
        if (commit_s) begin
            if (key_r == NO_KEY) begin
                key_s     = cand_s;
                pressed_s = 1'b1;
                strobe_s  = 1'b1;
            end else begin
                key_s     = NO_KEY;
                pressed_s = 1'b0;
            end
        end else begin
            key_s     = key_r;
            pressed_s = pressed_r;
        end
    end

    // Scan state, row drive and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ROW0;
            dwell_r <= '0;
            rows_r  <= 4'b1110;
            hit_r   <= 2'd0;
            code_r  <= NO_KEY;
        end else begin
            state_r <= state_s;
            dwell_r <= dwell_s;
            rows_r  <= row_drive(state_s);
            if (sample_s) begin
                hit_r  <= hit_s;
                code_r <= code_s;
            end
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_r    <= NO_KEY;
            stable_r  <= '0;
            key_r     <= NO_KEY;
            pressed_r <= 1'b0;
            strobe_r  <= 1'b0;
        end else begin
            cand_r    <= cand_s;
            stable_r  <= stable_s;
            key_r     <= key_s;
            pressed_r <= pressed_s;
            strobe_r  <= strobe_s;
        end
    end

    assign rows           = rows_r;
    assign key            = key_r;
    assign keypad_pressed = pressed_r;
    assign press_strobe   = strobe_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model answers the row drive, and a
// scan-level reference model of the debounce rules predicts every output cycle.
module tb_keypad_scanner;
    localparam int SETTLE = 4;
    localparam int DEB    = 3;
    localparam int SCAN   = 4 * SETTLE;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [4:0] key;
    logic       keypad_pressed;
    logic       press_strobe;

    int vectors = 0;
    int miscompares = 0;

    // physical keypad: bit r*4+c set means the key at row r, column c is held
    logic [15:0] held = 16'h0000;
    int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    // reference model state
    int m_cand;
    int m_stable;
    int m_key;
    int m_pressed;
    int m_strobe;

    keypad_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cols          (cols),
        .rows          (rows),
        .key           (key),
        .keypad_pressed(keypad_pressed),
        .press_strobe  (press_strobe)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] pad_cols(input logic [3:0] r, input logic [15:0] h);
        logic [3:0] c;
        c = 4'b1111;
        for (int ri = 0; ri < 4; ri++) begin
            if (!r[ri]) begin
                for (int ci = 0; ci < 4; ci++) begin
                    if (h[ri*4+ci]) c[ci] = 1'b0;
                end
            end
        end
        return c;
    endfunction

    function automatic int scan_value(input logic [15:0] h);
        int idx;
        idx = 0;
        if ($countones(h) != 1) return 31;
        for (int i = 0; i < 16; i++) if (h[i]) idx = i;
        return keymap[idx];
    endfunction

    task automatic model_reset();
        m_cand = 31; m_stable = 0; m_key = 31; m_pressed = 0; m_strobe = 0;
    endtask

    task automatic model_scan(input logic [15:0] h);
        int res;
        res = scan_value(h);
        if (res == m_cand) begin
            if (m_stable < DEB) m_stable++;
        end else begin
            m_cand = res;
            m_stable = 1;
        end
        m_strobe = 0;
        if (m_stable == DEB && m_cand != m_key) begin
            if (m_key == 31) begin
                m_key = m_cand; m_pressed = 1; m_strobe = 1;
            end else begin
                m_key = 31; m_pressed = 0;
            end
        end
    endtask

    // Runs one full scan (entered on the negedge that starts it), checking every cycle.
    task automatic run_scan(input logic [15:0] mask);
        logic [3:0] er;
        held = mask;
        for (int j = 0; j < SCAN; j++) begin
            cols = pad_cols(rows, held);
            er = 4'b0001 << (j / SETTLE);
            er = ~er;
            check_value("rows", int'(rows), int'(er));
            check_value("key", int'(key), m_key);
            check_value("pressed", int'(keypad_pressed), m_pressed);
            check_value("strobe", int'(press_strobe), (j == 0) ? m_strobe : 0);
            @(negedge clk);
        end
        model_scan(mask);
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) begin
            cols = pad_cols(rows, held);
            @(negedge clk);
        end
    endtask

    task automatic reset_outputs_check(input string tag);
        check_value({tag, "_rows"}, int'(rows), 14);
        check_value({tag, "_key"}, int'(key), 31);
        check_value({tag, "_pressed"}, int'(keypad_pressed), 0);
        check_value({tag, "_strobe"}, int'(press_strobe), 0);
    endtask

    initial begin
        logic [15:0] one;
        logic [15:0] cur;
        int sel;
        int len;
        one = 16'h0001;
        cur = 16'h0000;
        rst = 1'b1;
        cols = 4'b1111;
        model_reset();
        repeat (3) @(negedge clk);
        reset_outputs_check("reset");
        rst = 1'b0;

        // idle keypad
        repeat (13) run_scan(16'h0000);

        // clean STB press and release
        repeat (5) run_scan(16'h8000);
        check_value("stb_held", int'(key), 13);
        repeat (5) run_scan(16'h0000);
        check_value("stb_released", int'(key), 31);

        // bouncing PWRB
        for (int b = 0; b < 6; b++) run_scan((b % 2 == 0) ? 16'h0008 : 16'h0000);
        repeat (5) run_scan(16'h0008);
        check_value("pwrb_held", int'(key), 10);
        repeat (4) run_scan(16'h0000);

        // YES then directly NO
        repeat (5) run_scan(16'h4000);
        repeat (6) run_scan(16'h1000);
        check_value("no_held", int'(key), 14);
        repeat (4) run_scan(16'h0000);

        // ghosting: keys 5 and 6, then only 5
        repeat (5) run_scan(16'h0060);
        check_value("ghost_none", int'(key), 31);
        repeat (5) run_scan(16'h0020);
        check_value("five_held", int'(key), 5);
        repeat (4) run_scan(16'h0000);

        // reset while STB is committed, mid-scan
        repeat (4) run_scan(16'h8000);
        idle_cycles(6);
        rst = 1'b1;
        #1;
        reset_outputs_check("midreset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) run_scan(16'h8000);
        check_value("stb_recommit", int'(key), 13);
        repeat (4) run_scan(16'h0000);

        // randomized hold patterns
        for (int b = 0; b < 40; b++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin
                cur = one << $urandom_range(0, 15);
            end else if (sel < 6) begin
                cur = 16'h0000;
            end else if (sel < 8) begin
                cur = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
            end else begin
                cur = cur ^ (one << $urandom_range(0, 15));
            end
            len = int'($urandom_range(1, 5));
            repeat (len) run_scan(cur);
        end
        repeat (5) run_scan(16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
